// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier for signed two's-complement operands.
// One Booth step per clock: encode {Q[0], q_1}, add/subtract/skip the
// multiplicand into the accumulator, then arithmetic-shift {A,Q,q_1} right.
// A start/done handshake frames each product; o_p holds the last result.
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_x,
    input  logic [WIDTH-1:0]   i_y,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_p,
    output logic               o_plus,
    output logic               o_minus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [WIDTH:0]       m_q;      // sign-extended multiplicand
    logic [WIDTH:0]       a_q;      // accumulator, one guard bit wide
    logic [WIDTH-1:0]     q_q;      // multiplier, shifted out LSB first
    logic                 q1_q;     // the Booth "q minus one" bit
    logic [CW-1:0]        cnt_q;    // remaining Booth steps
    logic [2*WIDTH-1:0]   p_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 plus;
    logic                 minus;
    logic [WIDTH:0]       s_d;
    logic [WIDTH:0]       a_d;
    logic [WIDTH-1:0]     q_d;
    logic                 q1_d;

    // Booth encode of the current multiplier bit pair; silent outside RUN.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        plus  = 1'b0;
        minus = 1'b0;
        if (state_q == S_RUN) begin
            plus  = ~q_q[0] &  q1_q;
            minus =  q_q[0] & ~q1_q;
        end
    end

    // Partial-product update followed by the arithmetic right shift of {S,Q,q_1}.
    always_comb begin
        s_d = a_q;
        if (plus) begin
            s_d = a_q + m_q;
        end else if (minus) begin
            s_d = a_q - m_q;
        end
        a_d  = {s_d[WIDTH], s_d[WIDTH:1]};
        q_d  = {s_d[0], q_q[WIDTH-1:1]};
        q1_d = q_q[0];
    end

    // Control FSM and datapath registers; outputs are registered here.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            // NOTE: reset is synchronous and clears the whole datapath, so an aborted product leaves nothing behind.
            state_q <= S_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        m_q     <= {i_x[WIDTH-1], i_x};
                        a_q     <= '0;
                        q_q     <= i_y;
                        q1_q    <= 1'b0;
                        cnt_q   <= CW'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    q1_q  <= q1_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        p_q     <= {a_d[WIDTH-1:0], q_d};
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_p     = p_q;
    assign o_plus  = plus;
    assign o_minus = minus;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and randomized checks for booth_seq_mult at WIDTH=8 and WIDTH=5.
module tb_booth_seq_mult;

    logic        clk;
    logic        rst;

    logic        start8;
    logic [7:0]  x8;
    logic [7:0]  y8;
    logic        busy8;
    logic        done8;
    logic [15:0] p8;
    logic        plus8;
    logic        minus8;

    logic        start5;
    logic [4:0]  x5;
    logic [4:0]  y5;
    logic        busy5;
    logic        done5;
    logic [9:0]  p5;
    logic        plus5;
    logic        minus5;

    int errors;
    int checks;
    int both_cnt;

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start8),
        .i_x     (x8),
        .i_y     (y8),
        .o_busy  (busy8),
        .o_done  (done8),
        .o_p     (p8),
        .o_plus  (plus8),
        .o_minus (minus8)
    );

    booth_seq_mult #(.WIDTH(5)) dut5 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start5),
        .i_x     (x5),
        .i_y     (y5),
        .o_busy  (busy5),
        .o_done  (done5),
        .o_p     (p5),
        .o_plus  (plus5),
        .o_minus (minus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plus and minus must never be asserted together on either instance.
    always @(negedge clk) begin
        if ((plus8 && minus8) || (plus5 && minus5)) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One product on the 8-bit instance; lat counts the done cycle as cycle 1 + edges after accept.
    task automatic mult8(input logic [7:0] x, input logic [7:0] y,
                         output logic [15:0] p, output int lat);
        x8 = x;
        y8 = y;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 40) begin
            tick();
            lat++;
        end
        p = p8;
        tick();
    endtask

    task automatic mult5(input logic [4:0] x, input logic [4:0] y,
                         output logic [9:0] p, output int lat);
        x5 = x;
        y5 = y;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        lat = 1;
        while (!done5 && lat < 40) begin
            tick();
            lat++;
        end
        p = p5;
        tick();
    endtask

    initial begin
        logic [15:0] p;
        logic [9:0]  q;
        int          lat;
        logic [7:0]  plus_v;
        logic [7:0]  minus_v;
        int          ndone;
        int          d1;
        int          d2;
        logic [15:0] pd1;
        logic [15:0] pd2;
        int          cyc;

        errors   = 0;
        checks   = 0;
        both_cnt = 0;
        rst      = 1'b1;
        start8   = 1'b0;
        start5   = 1'b0;
        x8 = '0; y8 = '0; x5 = '0; y5 = '0;
        tick();
        tick();

        check("reset_busy",  {31'd0, busy8},  32'd0);
        check("reset_done",  {31'd0, done8},  32'd0);
        check("reset_p",     {16'd0, p8},     32'd0);
        check("reset_plus",  {31'd0, plus8},  32'd0);
        check("reset_minus", {31'd0, minus8}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic 3 x 5 with Booth encode trace.
        x8 = 8'd3;
        y8 = 8'd5;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("busy_after_accept", {31'd0, busy8}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            plus_v[k]  = plus8;
            minus_v[k] = minus8;
            tick();
        end
        check("trace_plus",  {24'd0, plus_v},  32'h0A);
        check("trace_minus", {24'd0, minus_v}, 32'h05);
        check("done_at_cycle9", {31'd0, done8}, 32'd1);
        check("p_3x5", {16'd0, p8}, 32'h000F);
        tick();
        check("done_one_cycle", {31'd0, done8}, 32'd0);
        check("busy_low_after", {31'd0, busy8}, 32'd0);

        // Sign cases.
        mult8(8'd127, 8'hFF, p, lat);
        check("p_127xm1", {16'd0, p}, 32'hFF81);
        check("lat_127xm1", lat, 32'd9);
        mult8(8'h80, 8'h80, p, lat);
        check("p_m128xm128", {16'd0, p}, 32'h4000);
        mult8(8'h80, 8'd127, p, lat);
        check("p_m128x127", {16'd0, p}, 32'hC080);
        mult8(8'd0, 8'hB3, p, lat);
        check("p_0xm77", {16'd0, p}, 32'h0000);

        // Busy rejection: extra starts in RUN and DONE are ignored.
        x8 = 8'd3;
        y8 = 8'd5;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done8) ndone++;
            start8 = (c == 3) || done8;
            if (c == 3) begin
                x8 = 8'd9;
                y8 = 8'd9;
            end
            tick();
        end
        start8 = 1'b0;
        check("reject_done_count", ndone, 32'd1);
        check("reject_p", {16'd0, p8}, 32'h000F);
        check("reject_busy_low", {31'd0, busy8}, 32'd0);

        // Back-to-back with i_start held high.
        x8 = 8'hFE;
        y8 = 8'd7;
        start8 = 1'b1;
        tick();
        x8 = 8'd6;
        y8 = 8'hFA;
        d1 = 0; d2 = 0; pd1 = '0; pd2 = '0;
        for (cyc = 1; cyc <= 19; cyc++) begin
            if (done8) begin
                if (d1 == 0) begin
                    d1  = cyc;
                    pd1 = p8;
                end else begin
                    d2  = cyc;
                    pd2 = p8;
                end
            end
            if (cyc == 19) start8 = 1'b0;
            tick();
        end
        tick();
        check("b2b_first_cycle",  d1, 32'd9);
        check("b2b_second_cycle", d2, 32'd19);
        check("b2b_p1", {16'd0, pd1}, 32'hFFF2);
        check("b2b_p2", {16'd0, pd2}, 32'hFFDC);
        check("b2b_idle", {31'd0, busy8}, 32'd0);

        // Reset during RUN step 4.
        x8 = 8'd100;
        y8 = 8'd100;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_p",    {16'd0, p8},    32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done8) ndone++;
            tick();
        end
        check("abort_no_done", ndone, 32'd0);
        mult8(8'd2, 8'd2, p, lat);
        check("p_2x2", {16'd0, p}, 32'h0004);

        // Reset together with start drops the start.
        x8 = 8'd5;
        y8 = 8'd5;
        start8 = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start8 = 1'b0;
        check("rst_start_busy", {31'd0, busy8}, 32'd0);
        tick();
        check("rst_start_idle", {31'd0, busy8}, 32'd0);

        // Random sweep against a signed reference product.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] xv;
            logic [7:0] yv;
            int         xi;
            int         yi;
            xv = 8'($urandom);
            yv = 8'($urandom);
            xi = int'($signed(xv));
            yi = int'($signed(yv));
            mult8(xv, yv, p, lat);
            check("rand8_p", {16'd0, p}, {16'd0, 16'(xi * yi)});
            check("rand8_lat", lat, 32'd9);
        end
        for (int i = 0; i < 1000; i++) begin
            logic [4:0] xv;
            logic [4:0] yv;
            int         xi;
            int         yi;
            xv = 5'($urandom);
            yv = 5'($urandom);
            xi = int'($signed(xv));
            yi = int'($signed(yv));
            mult5(xv, yv, q, lat);
            check("rand5_p", {22'd0, q}, {22'd0, 10'(xi * yi)});
            check("rand5_lat", lat, 32'd6);
        end

        check("plus_minus_exclusive", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_seq_mult.md
# booth_seq_mult

Iterative radix-2 Booth multiplier for signed two's-complement operands. It is the encoding side of the Booth scheme. Each cycle it examines the multiplier bit pair {q0, q−1}, generates the plus/minus control, and applies add/subtract/none to a running partial product, followed by an arithmetic right shift. It sits beside the combinational array multiplier as a low-area alternative and uses a start/done handshake.

## Interface
- WIDTH, 8, operand width in bits (≥ 2); product is 2·WIDTH bits.

- i_clk  input  1  clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  request; sampled only in IDLE.
- i_x  input  WIDTH  multiplicand (signed); sampled with accepted i_start.
- i_y  input  WIDTH  multiplier (signed); sampled with accepted i_start.
- o_busy  output  1  high in RUN and DONE.
- o_done  output  1  one-cycle pulse; o_p valid.
- o_p  output  2·WIDTH  signed product; held until next accepted start.
- o_plus  output  1  Booth encode for the current RUN step: add multiplicand.
- o_minus  output  1  Booth encode for the current RUN step: subtract multiplicand.

## Operation
- Registers:
  - M: WIDTH+1, sign-extended i_x.
  - A: WIDTH+1 accumulator.
  - Q: WIDTH.
  - q_1: 1 bit.
  - cnt: ⌈log2(WIDTH+1)⌉ bits.
  - state: IDLE/RUN/DONE.
  - P: 2·WIDTH output register.
- IDLE:
  - i_start=1 loads M←sext(i_x), A←0, Q←i_y, q_1←0, cnt←WIDTH, then → RUN.
  - i_start=0 stays in IDLE.
- RUN (combinational encode from {Q[0], q_1}):
  - 01 → o_plus=1.
  - 10 → o_minus=1.
  - 00 or 11 → neither.
  - o_plus and o_minus are never both 1.
- RUN step per edge:
  - S = A+M (plus), A−M (minus), or A (neither), all in WIDTH+1 bits.
  - Then {A,Q,q_1} ← arithmetic right shift of {S,Q,q_1}; S's MSB is replicated.
  - cnt ← cnt−1.
  - On the step where cnt=1: P ← {A_next[WIDTH−1:0], Q_next}, then → DONE.
- DONE:
  - o_done=1 for exactly this cycle, then → IDLE unconditionally.
  - i_start in DONE is ignored.
- o_p = P at all times. P changes only on the completion step and on reset.
- i_start in RUN or DONE is ignored. Operand inputs are don't-care outside the accept cycle.
- WIDTH+1 accumulator guarantees no overflow, including −2^(WIDTH−1) × −2^(WIDTH−1).

## Timing
- Reset (takes effect on the next edge with i_reset=1, overrides everything):
  - state=IDLE.
  - o_busy=0, o_done=0, o_plus=0, o_minus=0.
  - o_p=0.
  - A, Q, q_1, cnt, M cleared.
- Accept edge E0 (i_start=1 in IDLE):
  - RUN occupies the cycles after E0 through E_WIDTH.
  - o_done is high in the cycle following edge E_WIDTH.
  - Latency from the accept edge to the o_done cycle is WIDTH+1 cycles.
  - Next accept is possible at the edge ending the DONE cycle + 1 (IDLE). Throughput is one product per WIDTH+2 cycles.
- o_busy rises in the cycle after E0 and falls with the return to IDLE.
- o_plus and o_minus are zero outside RUN. They are combinational from registered state only (no input paths).
- Reset mid-RUN or in DONE: abort and return to IDLE with o_p=0. No o_done pulse is produced.
- Reset and i_start asserted together: reset wins and the start is dropped.

## Test plan
- Basic product, WIDTH=8: x=3, y=5, start one cycle.
  - o_done exactly 9 cycles after the accept edge.
  - o_p=0x000F.
  - plus/minus trace: minus at step 0, plus at step 1, minus at step 2, plus at step 3, then neither.
- Sign cases, WIDTH=8:
  - 127×−1 → 0xFF81.
  - −128×−128 → 0x4000.
  - −128×127 → 0xC080.
  - 0×−77 → 0x0000.
- Busy rejection: start 3×5, pulse i_start with x=9, y=9 during RUN and again during DONE.
  - Only one o_done pulse.
  - o_p=0x000F.
  - o_busy low afterward.
- Back-to-back: hold i_start=1 continuously with x=−2, y=7, then change to x=6, y=−6 after the first accept.
  - o_done pulses every 10 cycles.
  - o_p=0xFFF2, then 0xFFDC.
- Reset mid-operation: start 100×100, assert i_reset at RUN step 4.
  - Next cycle: o_busy=0, o_p=0, no o_done.
  - Subsequent 2×2 → 0x0004.
- Random sweep: 1000 random signed pairs at WIDTH=8 and WIDTH=5.
  - o_p matches the signed reference product.
  - o_plus & o_minus never both high.
